// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
//   ibuf_entry_t : one buffered instruction {pc, inst, excp}
//   IB_DEPTH     : default number of buffer entries
package inst_buffer_pkg;

  localparam int unsigned IB_DEPTH = 8;
  localparam int unsigned XLEN     = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            excp;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_mem.sv
// Instruction buffer storage: DEPTH x ibuf_entry_t register file.
//   clk     : write clock
//   we_i    : per-port write enable (port 1 only used together with port 0)
//   waddr_i : per-port write index
//   wdata_i : per-port write entry
//   raddr_i : per-port asynchronous read index
//   rdata_o : per-port read entry
// Storage carries no reset; validity is tracked by the owner.
module ibuf_mem
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic        [1:0]        we_i,
  input  logic        [1:0][PTR_W-1:0] waddr_i,
  input  ibuf_entry_t [1:0]        wdata_i,
  input  logic        [1:0][PTR_W-1:0] raddr_i,
  output ibuf_entry_t [1:0]        rdata_o
);

  ibuf_entry_t mem_q [DEPTH];

  // Two write ports; the owner never targets the same index from both.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i[i]] <= wdata_i[i];
      end
    end
  end

  assign rdata_o[0] = mem_q[raddr_i[0]];
  assign rdata_o[1] = mem_q[raddr_i[1]];

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular queue that
// accepts up to two instructions per cycle and presents the two oldest.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : drop all entries and any same-cycle push/pop
//   if_valid   : fetch slot valids (slot 1 honoured only with slot 0)
//   if_pc/if_inst/if_excp : fetch slot payloads
//   if_ready   : buffer has room for two entries this cycle
//   id_valid   : head / head+1 hold valid entries
//   id_pc/id_inst/id_excp : head / head+1 payloads
//   id_accept  : decode consumes head (bit 0) and head+1 (bit 1)
//   count      : current occupancy 0..DEPTH
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = IB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            if_valid,
  input  logic [1:0][XLEN-1:0]  if_pc,
  input  logic [1:0][XLEN-1:0]  if_inst,
  input  logic [1:0]            if_excp,
  output logic                  if_ready,
  output logic [1:0]            id_valid,
  output logic [1:0][XLEN-1:0]  id_pc,
  output logic [1:0][XLEN-1:0]  id_inst,
  output logic [1:0]            id_excp,
  input  logic [1:0]            id_accept,
  output logic [PTR_W:0]        count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             if_ready_q, if_ready_d;
  logic [1:0]       id_valid_q, id_valid_d;

  logic [1:0]       push_n;
  logic [1:0]       pop_n;

  logic        [1:0]            we;
  logic        [1:0][PTR_W-1:0] waddr;
  ibuf_entry_t [1:0]            wdata;
  logic        [1:0][PTR_W-1:0] raddr;
  ibuf_entry_t [1:0]            rdata;

  // Push/pop sizing from registered handshake state only.
  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (if_ready_q && if_valid[0]) begin
      push_n = if_valid[1] ? 2'd2 : 2'd1;
    end
    if (id_accept[0] && id_valid_q[0]) begin
      pop_n = (id_accept[1] && id_valid_q[1]) ? 2'd2 : 2'd1;
    end
  end

  // Pointer/occupancy next state; flush overrides any push or pop.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    if_ready_d    = (count_d <= CNT_W'(DEPTH - 2));
    id_valid_d[0] = (count_d != '0);
    id_valid_d[1] = (count_d >= CNT_W'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      if_ready_q <= 1'b1;
      id_valid_q <= 2'b00;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if_ready_q <= if_ready_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Storage write/read port hookup.
  always_comb begin
    we[0]    = !flush && (push_n != 2'd0);
    we[1]    = !flush && (push_n == 2'd2);
    waddr[0] = tail_q;
    waddr[1] = tail_q + PTR_W'(1);
    raddr[0] = head_q;
    raddr[1] = head_q + PTR_W'(1);
    for (int i = 0; i < 2; i++) begin
      wdata[i].pc   = if_pc[i];
      wdata[i].inst = if_inst[i];
      wdata[i].excp = if_excp[i];
    end
  end

  ibuf_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      id_pc[i]   = rdata[i].pc;
      id_inst[i] = rdata[i].inst;
      id_excp[i] = rdata[i].excp;
    end
  end

  assign if_ready = if_ready_q;
  assign id_valid = id_valid_q;
  assign count    = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer using a queue-based reference model.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       if_valid;
  logic [1:0][31:0] if_pc;
  logic [1:0][31:0] if_inst;
  logic [1:0]       if_excp;
  logic             if_ready;
  logic [1:0]       id_valid;
  logic [1:0][31:0] id_pc;
  logic [1:0][31:0] id_inst;
  logic [1:0]       id_excp;
  logic [1:0]       id_accept;
  logic [3:0]       count;

  int checks = 0;
  int errors = 0;

  ibuf_entry_t mq[$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_excp   (if_excp),
    .if_ready  (if_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_excp   (id_excp),
    .id_accept (id_accept),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_valid();
    return {mq.size() >= 2, mq.size() >= 1};
  endfunction

  function automatic logic exp_ready();
    return mq.size() <= DEPTH - 2;
  endfunction

  // Drive one cycle of stimulus, clock it, and advance the reference model.
  task automatic drive(input logic fl, input logic [1:0] v,
                       input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] acc);
    ibuf_entry_t e0, e1;
    int sz;
    int popn;
    bit rdy;
    e0.pc = pc0; e0.inst = $urandom; e0.excp = 1'($urandom);
    e1.pc = pc1; e1.inst = $urandom; e1.excp = 1'($urandom);
    flush     = fl;
    if_valid  = v;
    if_pc[0]  = e0.pc;   if_pc[1]  = e1.pc;
    if_inst[0]= e0.inst; if_inst[1]= e1.inst;
    if_excp   = {e1.excp, e0.excp};
    id_accept = acc;
    @(posedge clk);
    sz   = mq.size();
    rdy  = (sz <= DEPTH - 2);
    popn = 0;
    if (fl) begin
      mq.delete();
    end else begin
      if (acc[0] && sz >= 1) popn = (acc[1] && sz >= 2) ? 2 : 1;
      repeat (popn) void'(mq.pop_front());
      if (rdy && v[0]) begin
        mq.push_back(e0);
        if (v[1]) mq.push_back(e1);
      end
    end
    #1;
    flush = 1'b0; if_valid = 2'b00; id_accept = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; if_valid = 2'b00; id_accept = 2'b00;
    if_pc = '0; if_inst = '0; if_excp = '0;
    #1;
    checks++;
    if (id_valid !== 2'b00 || if_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset_active: valid=%b ready=%b count=%0d, want 00/1/0", id_valid, if_ready, count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    @(posedge clk); #1;
    checks++;
    if (id_valid !== 2'b00 || if_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset_after: valid=%b ready=%b count=%0d, want 00/1/0", id_valid, if_ready, count);
    end
    drive(1'b0, 2'b11, 32'h1c00_0000, 32'h1c00_0004, 2'b00);
    checks++;
    if (id_valid !== 2'b11 || id_pc[0] !== 32'h1c00_0000 || id_pc[1] !== 32'h1c00_0004) begin
      errors++;
      $display("FAIL first_push: valid=%b pc0=%h pc1=%h, want 11 1c000000 1c000004", id_valid, id_pc[0], id_pc[1]);
    end
    checks++;
    if (id_inst[0] !== mq[0].inst || id_inst[1] !== mq[1].inst ||
        id_excp !== {mq[1].excp, mq[0].excp}) begin
      errors++;
      $display("FAIL first_payload: inst0=%h inst1=%h excp=%b, want %h %h %b",
               id_inst[0], id_inst[1], id_excp, mq[0].inst, mq[1].inst, {mq[1].excp, mq[0].excp});
    end
  endtask

  task automatic test_fill();
    logic [31:0] base = 32'h1000_0000;
    drive(1'b1, 2'b00, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b11, base + 32'(8*i), base + 32'(8*i+4), 2'b00);
    checks++;
    if (count !== 4'd8 || if_ready !== 1'b0 || id_valid !== 2'b11) begin
      errors++;
      $display("FAIL full: count=%0d ready=%b valid=%b, want 8/0/11", count, if_ready, id_valid);
    end
    drive(1'b0, 2'b11, 32'hbad0_0000, 32'hbad0_0004, 2'b00);
    checks++;
    if (count !== 4'd8 || id_pc[0] !== base || id_pc[1] !== base + 32'd4) begin
      errors++;
      $display("FAIL push_when_full: count=%0d pc0=%h pc1=%h, want 8 %h %h", count, id_pc[0], id_pc[1], base, base + 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (id_pc[0] !== base + 32'(8*i) || id_pc[1] !== base + 32'(8*i+4)) begin
        errors++;
        $display("FAIL drain_%0d: pc0=%h pc1=%h, want %h %h", i, id_pc[0], id_pc[1], base + 32'(8*i), base + 32'(8*i+4));
      end
      drive(1'b0, 2'b00, 0, 0, 2'b11);
    end
    checks++;
    if (count !== 4'd0 || id_valid !== 2'b00 || if_ready !== 1'b1) begin
      errors++;
      $display("FAIL drained: count=%0d valid=%b ready=%b, want 0/00/1", count, id_valid, if_ready);
    end
  endtask

  task automatic test_mixed();
    logic [31:0] a = 32'h2000_0000;
    drive(1'b1, 2'b00, 0, 0, 2'b00);
    drive(1'b0, 2'b11, a, a + 32'd4, 2'b00);
    drive(1'b0, 2'b01, a + 32'd8, 32'hffff_ffff, 2'b00);
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL mixed_setup: count=%0d, want 3", count);
    end
    drive(1'b0, 2'b11, a + 32'd12, a + 32'd16, 2'b01);
    checks++;
    if (count !== 4'd4 || id_pc[0] !== a + 32'd4 || id_pc[1] !== a + 32'd8) begin
      errors++;
      $display("FAIL mixed_push2_pop1: count=%0d pc0=%h pc1=%h, want 4 %h %h", count, id_pc[0], id_pc[1], a + 32'd4, a + 32'd8);
    end
    drive(1'b0, 2'b00, 0, 0, 2'b11);
    checks++;
    if (count !== 4'd2 || id_pc[0] !== a + 32'd12 || id_pc[1] !== a + 32'd16) begin
      errors++;
      $display("FAIL mixed_order: count=%0d pc0=%h pc1=%h, want 2 %h %h", count, id_pc[0], id_pc[1], a + 32'd12, a + 32'd16);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w = 32'h3000_0000;
    logic [31:0] exp_pc;
    drive(1'b1, 2'b00, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b11, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 0, 0, 2'b11);
    // Head and tail now sit at index 6; the next 6 entries straddle 7 -> 0.
    exp_pc = w;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (id_valid !== exp_valid()) begin
        errors++;
        $display("FAIL wrap_valid_%0d: valid=%b, want %b", c, id_valid, exp_valid());
      end
      if (id_valid[0]) begin
        checks++;
        if (id_pc[0] !== exp_pc) begin
          errors++;
          $display("FAIL wrap_pc0_%0d: pc=%h, want %h", c, id_pc[0], exp_pc);
        end
        exp_pc += 32'd4;
      end
      if (id_valid[1]) begin
        checks++;
        if (id_pc[1] !== exp_pc) begin
          errors++;
          $display("FAIL wrap_pc1_%0d: pc=%h, want %h", c, id_pc[1], exp_pc);
        end
        exp_pc += 32'd4;
      end
      if (c < 3) drive(1'b0, 2'b11, w + 32'(8*c), w + 32'(8*c+4), 2'b11);
      else       drive(1'b0, 2'b00, 0, 0, 2'b11);
    end
    checks++;
    if (exp_pc !== w + 32'd24 || count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_complete: last_pc=%h count=%0d, want %h 0", exp_pc, count, w + 32'd24);
    end
  endtask

  task automatic test_flush();
    logic [31:0] f = 32'h4000_0000;
    drive(1'b1, 2'b00, 0, 0, 2'b00);
    drive(1'b0, 2'b11, f, f + 32'd4, 2'b00);
    drive(1'b0, 2'b11, f + 32'd8, f + 32'd12, 2'b00);
    drive(1'b0, 2'b01, f + 32'd16, 32'h0, 2'b00);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL flush_setup: count=%0d, want 5", count);
    end
    drive(1'b1, 2'b11, 32'hdead_0000, 32'hdead_0004, 2'b11);
    checks++;
    if (count !== 4'd0 || id_valid !== 2'b00 || if_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b ready=%b, want 0/00/1", count, id_valid, if_ready);
    end
    drive(1'b0, 2'b11, 32'h5000_0000, 32'h5000_0004, 2'b00);
    checks++;
    if (count !== 4'd2 || id_pc[0] !== 32'h5000_0000 || id_pc[1] !== 32'h5000_0004) begin
      errors++;
      $display("FAIL post_flush: count=%0d pc0=%h pc1=%h, want 2 50000000 50000004", count, id_pc[0], id_pc[1]);
    end
    drive(1'b0, 2'b00, 0, 0, 2'b11);
    checks++;
    if (id_valid !== 2'b00) begin
      errors++;
      $display("FAIL flush_no_ghost: valid=%b pc0=%h, want 00", id_valid, id_pc[0]);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b00, 0, 0, 2'b00);
    drive(1'b0, 2'b10, 32'h6000_0000, 32'h6000_0004, 2'b00);
    checks++;
    if (count !== 4'd0 || id_valid !== 2'b00) begin
      errors++;
      $display("FAIL valid_10: count=%0d valid=%b, want 0 00", count, id_valid);
    end
    drive(1'b0, 2'b11, 32'h6000_0010, 32'h6000_0014, 2'b00);
    drive(1'b0, 2'b00, 0, 0, 2'b10);
    checks++;
    if (count !== 4'd2 || id_pc[0] !== 32'h6000_0010) begin
      errors++;
      $display("FAIL accept_10: count=%0d pc0=%h, want 2 60000010", count, id_pc[0]);
    end
    drive(1'b0, 2'b00, 0, 0, 2'b01);
    checks++;
    if (count !== 4'd1 || id_valid !== 2'b01 || id_pc[0] !== 32'h6000_0014) begin
      errors++;
      $display("FAIL accept_01: count=%0d valid=%b pc0=%h, want 1 01 60000014", count, id_valid, id_pc[0]);
    end
    drive(1'b0, 2'b00, 0, 0, 2'b11);
    checks++;
    if (count !== 4'd0 || id_valid !== 2'b00) begin
      errors++;
      $display("FAIL accept_11_one_valid: count=%0d valid=%b, want 0 00", count, id_valid);
    end
    drive(1'b0, 2'b11, 32'h7000_0000, 32'h7000_0004, 2'b00);
    drive(1'b0, 2'b11, 32'h7000_0008, 32'h7000_000c, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || id_valid !== 2'b00 || if_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: count=%0d valid=%b ready=%b, want 0/00/1", count, id_valid, if_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_random();
    logic fl;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (count !== 4'(mq.size()) || id_valid !== exp_valid() || if_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ctl_%0d: count=%0d valid=%b ready=%b, want %0d %b %b",
                 c, count, id_valid, if_ready, mq.size(), exp_valid(), exp_ready());
      end
      for (int s = 0; s < 2; s++) begin
        if (mq.size() > s) begin
          checks++;
          if (id_pc[s] !== mq[s].pc || id_inst[s] !== mq[s].inst || id_excp[s] !== mq[s].excp) begin
            errors++;
            $display("FAIL rand_data_%0d_s%0d: pc=%h inst=%h excp=%b, want %h %h %b",
                     c, s, id_pc[s], id_inst[s], id_excp[s], mq[s].pc, mq[s].inst, mq[s].excp);
          end
        end
      end
      fl = ($urandom_range(0, 24) == 0);
      drive(fl, 2'($urandom), $urandom, $urandom, 2'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_mixed();
    test_wrap();
    test_flush();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
